imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter ADDR_W, default 30, SHALL set the word-address width driven on sram_addr (1..30).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum cycles waited for sram_ack before the block faults (1..65535).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 imem_addr  input  32  SHALL be the byte fetch address from the program counter.
REQ-006 inv  input  1  SHALL be the invalidate request for the held instruction.
REQ-007 instr  output  32  SHALL be the fetched instruction word.
REQ-008 stall  output  1  SHALL be the hold request to the program counter (1 = instr not valid for imem_addr).
REQ-009 sram_req  output  1  SHALL be the read request to the instruction SRAM.
REQ-010 sram_addr  output  ADDR_W  SHALL be the SRAM word address.
REQ-011 sram_ack  input  1  SHALL be the SRAM completion strobe (1 cycle, rdata valid same cycle).
REQ-012 sram_rdata  input  32  SHALL be the SRAM read data.
REQ-013 fetch_err  output  1  SHALL be the sticky fault flag.

Function
REQ-014 Block SHALL hold one entry: instr_q[31:0], tag_q[29:0], tag_v.
REQ-015 hit SHALL be tag_v AND imem_addr[31:2]==tag_q, evaluated combinationally.
REQ-016 instr SHALL always equal instr_q.
REQ-017 stall SHALL be 0 only when state is IDLE and hit=1; otherwise 1 (combinational, same cycle as the miss).
REQ-018 States SHALL be IDLE, REQ and ERR.
REQ-019 IDLE with miss SHALL register sram_addr=imem_addr[ADDR_W+1:2], set sram_req=1, clear the wait counter and enter REQ next cycle.
REQ-020 In REQ, sram_req and sram_addr SHALL remain stable until the cycle sram_ack=1 is sampled.
REQ-021 On sram_ack in REQ, the block SHALL load instr_q=sram_rdata and tag_q=the requested word address, set tag_v=1, drop sram_req and return to IDLE; the miss penalty SHALL be (ack cycle - miss cycle + 1) cycles.
REQ-022 sram_ack outside REQ SHALL be ignored.
REQ-023 A change of imem_addr during REQ SHALL NOT alter the outstanding request; the hit check SHALL be repeated in IDLE afterwards.
REQ-024 inv in IDLE SHALL clear tag_v next cycle; inv in REQ SHALL set a drop flag so that the ack loads instr_q but leaves tag_v=0, forcing a re-request.
REQ-025 inv and sram_ack in the same REQ cycle SHALL behave as REQ-024 (drop wins).
REQ-026 The wait counter SHALL increment each REQ cycle without ack; reaching TIMEOUT SHALL enter ERR.
REQ-027 ERR SHALL hold stall=1, sram_req=0 and fetch_err=1 until rst; it SHALL have no other exit.

Reset
REQ-028 rst SHALL force state=IDLE, tag_v=0, drop flag=0, instr_q=0, tag_q=0, sram_req=0, sram_addr=0, counter=0 and fetch_err=0 at the next edge, from any state, including mid-REQ.
REQ-029 After reset the first fetch SHALL miss; stall SHALL be 1 in the cycle after rst deasserts if imem_addr is unchanged.
REQ-030 A late sram_ack from a request aborted by reset SHALL be ignored.

Configuration
REQ-031 With IMEM_ALIGN_CHK_EN defined, imem_addr[1:0]!=0 sampled in IDLE SHALL enter ERR without issuing sram_req.
REQ-032 Without IMEM_ALIGN_CHK_EN, imem_addr[1:0] SHALL be ignored and no alignment logic SHALL be synthesised.

Verification
REQ-033 rst, then imem_addr=0x0, ack after 3 cycles with rdata=0x2408000A -> stall=1 for 4 cycles, sram_addr=0, then instr=0x2408000A with stall=0.
REQ-034 Hit then branch: addr 0x4 held, then 0x40 -> 0x4 stays stall=0; 0x40 raises stall the same cycle and sram_addr=0x10.
REQ-035 inv asserted in the ack cycle for 0x8 -> tag_v stays 0 and a second sram_req with sram_addr=0x2 follows.
REQ-036 TIMEOUT=4, no ack -> ERR after 4 REQ cycles, fetch_err=1, sram_req=0, stall=1 until rst.
REQ-037 rst asserted mid-REQ then a stale ack -> state IDLE, instr=0, tag_v=0, ack ignored.
REQ-038 IMEM_ALIGN_CHK_EN defined, imem_addr=0x6 -> no sram_req, fetch_err=1 next cycle; undefined -> read issued to sram_addr=0x1.

Source files
------------

// File: rtl/imem_fetch.sv
// Single-entry instruction fetch buffer in front of an instruction SRAM with a bounded-wait fault.
// Optional IMEM_ALIGN_CHK_EN: a misaligned fetch address seen in IDLE faults instead of issuing a read.
module imem_fetch #(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       imem_addr,
  input  logic              inv,
  output logic [31:0]       instr,
  output logic              stall,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_ack,
  input  logic [31:0]       sram_rdata,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            r_state;
  logic [31:0]       r_instr;
  logic [29:0]       r_tag;
  logic              r_tag_v;
  logic [29:0]       r_req_tag;
  logic              r_drop;
  logic              r_sram_req;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [15:0]       r_cnt;
  logic              r_fetch_err;

  state_t            w_state_next;
  logic [31:0]       w_instr_next;
  logic [29:0]       w_tag_next;
  logic              w_tag_v_next;
  logic [29:0]       w_req_tag_next;
  logic              w_drop_next;
  logic              w_sram_req_next;
  logic [ADDR_W-1:0] w_sram_addr_next;
  logic [15:0]       w_cnt_next;
  logic              w_fetch_err_next;

  logic              w_hit;
  logic [16:0]       w_cnt_inc;

  assign w_hit     = r_tag_v && (imem_addr[31:2] == r_tag);
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

`ifdef IMEM_ALIGN_CHK_EN
  logic w_misaligned;
  assign w_misaligned = (imem_addr[1:0] != 2'b00);
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^imem_addr[1:0];
`endif

  assign instr     = r_instr;
  assign stall     = !((r_state == S_IDLE) && w_hit);
  assign sram_req  = r_sram_req;
  assign sram_addr = r_sram_addr;
  assign fetch_err = r_fetch_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_instr     <= 32'd0;
      r_tag       <= 30'd0;
      r_tag_v     <= 1'b0;
      r_req_tag   <= 30'd0;
      r_drop      <= 1'b0;
      r_sram_req  <= 1'b0;
      r_sram_addr <= '0;
      r_cnt       <= 16'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_instr     <= w_instr_next;
      r_tag       <= w_tag_next;
      r_tag_v     <= w_tag_v_next;
      r_req_tag   <= w_req_tag_next;
      r_drop      <= w_drop_next;
      r_sram_req  <= w_sram_req_next;
      r_sram_addr <= w_sram_addr_next;
      r_cnt       <= w_cnt_next;
      r_fetch_err <= w_fetch_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_instr_next     = r_instr;
    w_tag_next       = r_tag;
    w_tag_v_next     = r_tag_v;
    w_req_tag_next   = r_req_tag;
    w_drop_next      = r_drop;
    w_sram_req_next  = r_sram_req;
    w_sram_addr_next = r_sram_addr;
    w_cnt_next       = r_cnt;
    w_fetch_err_next = r_fetch_err;

    case (r_state)
      S_IDLE: begin
        if (inv) begin
          w_tag_v_next = 1'b0;
        end
`ifdef IMEM_ALIGN_CHK_EN
        if (w_misaligned) begin
          w_state_next     = S_ERR;
          w_sram_req_next  = 1'b0;
          w_fetch_err_next = 1'b1;
        end else
`endif
        if (!w_hit) begin
          w_state_next     = S_REQ;
          w_sram_req_next  = 1'b1;
          w_sram_addr_next = imem_addr[ADDR_W+1:2];
          w_req_tag_next   = imem_addr[31:2];
          w_cnt_next       = 16'd0;
          w_drop_next      = 1'b0;
        end
      end

      S_REQ: begin
        if (sram_ack) begin
          // Data is always captured; an invalidate seen during the fetch only withholds the tag.
          w_instr_next    = sram_rdata;
          w_tag_next      = r_req_tag;
          w_tag_v_next    = !(r_drop || inv);
          w_drop_next     = 1'b0;
          w_sram_req_next = 1'b0;
          w_state_next    = S_IDLE;
        end else begin
          if (inv) begin
            w_drop_next = 1'b1;
          end
          w_cnt_next = w_cnt_inc[15:0];
          if (w_cnt_inc >= 17'(TIMEOUT)) begin
            w_state_next     = S_ERR;
            w_sram_req_next  = 1'b0;
            w_fetch_err_next = 1'b1;
          end
        end
      end

      S_ERR: begin
        w_sram_req_next  = 1'b0;
        w_fetch_err_next = 1'b1;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch (TIMEOUT=4): fill latency, hit/branch, invalidate, timeout, reset abort, alignment.
module tb_imem_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic        inv;
  logic [31:0] instr;
  logic        stall;
  logic        sram_req;
  logic [29:0] sram_addr;
  logic        sram_ack;
  logic [31:0] sram_rdata;
  logic        fetch_err;

  int checks;
  int failures;

  imem_fetch #(.ADDR_W(30), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .inv        (inv),
    .instr      (instr),
    .stall      (stall),
    .sram_req   (sram_req),
    .sram_addr  (sram_addr),
    .sram_ack   (sram_ack),
    .sram_rdata (sram_rdata),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs set afterwards apply to the new cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle after input changes within the cycle.
  task automatic settle();
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    imem_addr  = 32'h0;
    inv        = 1'b0;
    sram_ack   = 1'b0;
    sram_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    // Reset state and first-fetch miss
    check("rst_instr", instr, 32'h0);
    check("rst_req", 32'(sram_req), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("miss_c0_stall", 32'(stall), 32'd1);
    $display("txn reset done, first fetch addr 0x0 misses");

    // Fill of word 0, ack in 3rd REQ cycle -> 4 stall cycles
    tick(); settle();
    check("fill_c1_stall", 32'(stall), 32'd1);
    check("fill_c1_req", 32'(sram_req), 32'd1);
    check("fill_c1_addr", 32'(sram_addr), 32'd0);
    tick(); settle();
    check("fill_c2_stall", 32'(stall), 32'd1);
    tick();
    sram_ack = 1'b1; sram_rdata = 32'h2408000A;
    settle();
    check("fill_c3_stall", 32'(stall), 32'd1);
    tick();
    sram_ack = 1'b0;
    settle();
    check("fill_c4_stall", 32'(stall), 32'd0);
    check("fill_c4_instr", instr, 32'h2408000A);
    check("fill_c4_req", 32'(sram_req), 32'd0);
    $display("txn fill addr 0x0 instr=0x%08h", instr);

    // Hit then branch
    imem_addr = 32'h4;
    settle();
    check("a4_miss_stall", 32'(stall), 32'd1);
    tick();
    check("a4_addr", 32'(sram_addr), 32'h1);
    sram_ack = 1'b1; sram_rdata = 32'h11111111;
    tick();
    sram_ack = 1'b0;
    settle();
    check("a4_hit_stall", 32'(stall), 32'd0);
    check("a4_instr", instr, 32'h11111111);
    tick(); settle();
    check("a4_hold_stall", 32'(stall), 32'd0);
    imem_addr = 32'h40;
    settle();
    check("a40_miss_stall", 32'(stall), 32'd1);
    tick();
    check("a40_addr", 32'(sram_addr), 32'h10);
    imem_addr = 32'h4;
    tick(); settle();
    check("a40_addr_stable", 32'(sram_addr), 32'h10);
    check("a40_req_stable", 32'(sram_req), 32'd1);
    sram_ack = 1'b1; sram_rdata = 32'h22222222;
    tick();
    sram_ack = 1'b0;
    settle();
    check("a40_recheck_stall", 32'(stall), 32'd1);
    check("a40_instr", instr, 32'h22222222);
    imem_addr = 32'h40;
    settle();
    check("a40_hit_stall", 32'(stall), 32'd0);
    $display("txn branch 0x4 -> 0x40 instr=0x%08h", instr);

    // Invalidate in the ack cycle
    imem_addr = 32'h8;
    tick();
    check("a8_addr", 32'(sram_addr), 32'h2);
    sram_ack = 1'b1; inv = 1'b1; sram_rdata = 32'h33333333;
    tick();
    sram_ack = 1'b0; inv = 1'b0;
    settle();
    check("inv_ack_instr", instr, 32'h33333333);
    check("inv_ack_stall", 32'(stall), 32'd1);
    tick(); settle();
    check("inv_rereq", 32'(sram_req), 32'd1);
    check("inv_rereq_addr", 32'(sram_addr), 32'h2);
    sram_ack = 1'b1;
    tick();
    sram_ack = 1'b0;
    settle();
    check("inv_refill_stall", 32'(stall), 32'd0);
    $display("txn inv during ack addr 0x8 re-requested");

    // Invalidate in IDLE, then ack outside REQ
    inv = 1'b1;
    settle();
    check("inv_idle_same_stall", 32'(stall), 32'd0);
    tick();
    inv = 1'b0;
    settle();
    check("inv_idle_stall", 32'(stall), 32'd1);
    tick();
    check("inv_idle_req", 32'(sram_req), 32'd1);
    sram_ack = 1'b1; sram_rdata = 32'h66666666;
    tick();
    sram_ack = 1'b1; sram_rdata = 32'hDEADBEEF;
    tick();
    sram_ack = 1'b0;
    settle();
    check("idle_ack_instr", instr, 32'h66666666);
    check("idle_ack_stall", 32'(stall), 32'd0);
    $display("txn inv in IDLE and stray ack ignored");

    // Reset mid-REQ, then stale ack
    imem_addr = 32'hC;
    tick();
    check("abort_req", 32'(sram_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sram_ack = 1'b1; sram_rdata = 32'h44444444;
    settle();
    check("abort_instr", instr, 32'h0);
    check("abort_req_clr", 32'(sram_req), 32'd0);
    check("abort_stall", 32'(stall), 32'd1);
    tick();
    sram_ack = 1'b0;
    settle();
    check("stale_instr", instr, 32'h0);
    check("stale_newreq", 32'(sram_req), 32'd1);
    check("stale_newreq_addr", 32'(sram_addr), 32'h3);
    sram_ack = 1'b1; sram_rdata = 32'h55555555;
    tick();
    sram_ack = 1'b0;
    settle();
    check("post_abort_instr", instr, 32'h55555555);
    check("post_abort_stall", 32'(stall), 32'd0);
    $display("txn reset mid-REQ, stale ack ignored");

    // Timeout after 4 REQ cycles
    imem_addr = 32'h100;
    tick(); tick(); tick(); tick(); settle();
    check("to_c4_req", 32'(sram_req), 32'd1);
    check("to_c4_err", 32'(fetch_err), 32'd0);
    tick(); settle();
    check("to_err", 32'(fetch_err), 32'd1);
    check("to_req", 32'(sram_req), 32'd0);
    check("to_stall", 32'(stall), 32'd1);
    sram_ack = 1'b1; sram_rdata = 32'h77777777; imem_addr = 32'h40;
    tick();
    sram_ack = 1'b0;
    tick(); settle();
    check("err_hold_err", 32'(fetch_err), 32'd1);
    check("err_hold_stall", 32'(stall), 32'd1);
    check("err_hold_instr", instr, 32'h55555555);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("err_rst", 32'(fetch_err), 32'd0);
    $display("txn timeout fault and reset recovery");

    // Alignment
    imem_addr = 32'h6;
    tick(); settle();
`ifdef IMEM_ALIGN_CHK_EN
    check("align_req", 32'(sram_req), 32'd0);
    check("align_err", 32'(fetch_err), 32'd1);
`else
    check("align_req", 32'(sram_req), 32'd1);
    check("align_addr", 32'(sram_addr), 32'h1);
    check("align_err", 32'(fetch_err), 32'd0);
`endif
    $display("txn fetch addr 0x6 req=%0d err=%0d", sram_req, fetch_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
